bcd_to_binary_seq: RTL and testbench
====================================

Name: bcd_to_binary_seq

Overview:
Sequential BCD-to-binary converter, the inverse of the team's combinational binary-to-BCD converter. It accepts a packed multi-digit BCD word over a valid/ready handshake and runs reverse double dabble, one iteration per clock. It returns the binary value over a second valid/ready handshake. It sits between BCD sources (keypad/display digit registers) and binary datapath logic.

Parameters:
DIGITS, 3, number of BCD digits in the input word.
BIN_W, 10, binary output width and iteration count. Must be >= ceil(log2(10^DIGITS)); 10 covers 0..999.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  synchronous, active-high reset.
bcd_in  input  4*DIGITS  packed BCD word; most significant digit in the top nibble (default: [11:8] hundreds, [7:4] tens, [3:0] ones).
in_valid  input  1  bcd_in is valid this cycle.
in_ready  output  1  block can accept an input; high only in IDLE.
bin_out  output  BIN_W  converted binary value; registered.
err  output  1  at least one input digit was > 9; qualified by out_valid.
out_valid  output  1  bin_out/err valid; held until accepted.
out_ready  input  1  consumer accepts the result.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values:
  - State = IDLE.
  - in_ready = 1 (combinational from state).
  - out_valid = 0, bin_out = 0, err = 0.
  - Iteration counter = 0.
  - Internal shift register = 0.
- FSM states: IDLE, CONV, DONE.
- IDLE, in_valid=1 (accept edge E0):
  - Load shift register {bcd_in, BIN_W'b0} (width 4*DIGITS+BIN_W).
  - Latch the digit-check result into an internal error flag. The flag is set if any nibble > 9.
  - Clear the counter and go to CONV.
  - in_valid=0 leaves the block in IDLE.
- CONV, each cycle performs one iteration:
  - Logical shift right of the whole register by 1; the bit shifted out of the BCD field enters the MSB of the binary field.
  - Then, for each BCD nibble of the shifted value, if nibble >= 8, subtract 3 (4-bit arithmetic, no inter-digit carry).
  - The counter increments. After the BIN_W-th iteration, go to DONE.
- DONE entry (edge E0+BIN_W):
  - out_valid rises at that edge and stays registered high.
  - bin_out = binary field of the register, unless the error flag is set. In that case bin_out = 0 and err = 1.
  - Latency is always exactly BIN_W cycles from the accept edge to out_valid, including the error case.
- DONE: out_valid=1 and out_ready=1 at an edge gives out_valid=0 and state IDLE.
  - in_ready rises the following cycle; there is no same-cycle bypass.
  - bin_out and err keep their last value after acceptance until the next result loads.
- Backpressure: while in DONE with out_ready=0, bin_out, err and out_valid hold stable indefinitely.
- in_valid outside IDLE is ignored. The input is not captured and not queued; the producer must hold in_valid until in_ready.
- bcd_in is sampled only at the accept edge; later changes have no effect on the conversion in progress.
- out_ready outside DONE is ignored.
- Value range: with valid digits the residual BCD field is all zeros after BIN_W iterations. No overflow output exists; the parameter constraint guarantees the fit.
- Reset mid-operation (CONV or DONE):
  - Next state = IDLE, out_valid = 0, bin_out = 0, err = 0.
  - The conversion is discarded and no result is emitted.
  - rst has priority over all handshake events in the same cycle.
- Simultaneous rst and in_valid: reset wins and the input is not accepted.

Test Plan:
1. Reset for 2 cycles, then bcd_in=0x255 with in_valid for one cycle -> in_ready drops next cycle; out_valid rises exactly 10 edges after accept; bin_out=0x0FF, err=0; out_ready=1 returns to IDLE and in_ready=1 one cycle later.
2. Boundaries -> 0x000 gives bin_out=0; 0x999 gives bin_out=999 (0x3E7); 0x100 gives 100 (0x064); 0x009 gives 9. Each has err=0 and 10-cycle latency.
3. Invalid digit: bcd_in=0x1A0 -> after 10 cycles out_valid=1, err=1, bin_out=0. Also bcd_in=0xF00 -> err=1.
4. Backpressure: convert 0x128, hold out_ready=0 for 6 cycles while pulsing in_valid with 0x777 -> bin_out stays 128 (0x080) and out_valid stays 1; in_ready=0 throughout; the 0x777 is never converted. Release out_ready -> single handshake.
5. Reset mid-conversion: accept 0x555, assert rst on the 4th CONV cycle -> out_valid never asserts, all outputs 0, in_ready=1 after reset. A following 0x042 converts to 42 (0x02A) with normal latency.
6. Back-to-back: stream 0x001, 0x064, 0x500 with in_valid held high and out_ready tied high -> results 1, 64, 500 in order. Each accept occurs one cycle after the previous output handshake, giving a period of BIN_W+2 cycles per result.

Source files
------------

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double dabble.
// Valid/ready on both sides; one shift/correct iteration per clock.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] sreg;
  logic [SW-1:0] step;
  logic [CW-1:0] cnt;
  logic          err_flag;
  logic          bad_digit;
  logic          last_iter;

  assign in_ready  = (state == IDLE);
  assign last_iter = (cnt == CW'(BIN_W - 1));

  // Shift, then pull each BCD nibble back from >=8 into base-2 range.
  always_comb begin
    step = sreg >> 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (step[BIN_W+4*i +: 4] >= 4'd8)
        step[BIN_W+4*i +: 4] = step[BIN_W+4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9)
        bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = CONV;
      CONV:    if (last_iter) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg      <= '0;
      cnt       <= '0;
      err_flag  <= 1'b0;
      bin_out   <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sreg     <= {bcd_in, BIN_W'(0)};
            err_flag <= bad_digit;
            cnt      <= '0;
          end
        end
        CONV: begin
          sreg <= step;
          cnt  <= cnt + CW'(1);
          if (last_iter) begin
            out_valid <= 1'b1;
            bin_out   <= err_flag ? '0 : step[BIN_W-1:0];
            err       <= err_flag;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed testbench for bcd_to_binary_seq.
// Drives and samples 1ns after each rising edge.
module tb_bcd_to_binary_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] bcd_in;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  bin_out;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_to_binary_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_out   (bin_out),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input logic [11:0] bcd,
                         input logic [9:0] exp_bin,
                         input logic exp_err,
                         input string name);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin tick(); n++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s in_ready_wait: got %b want 1", name, in_ready);
    end
    bcd_in   = bcd;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bcd_in   = 12'h3C3;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s in_ready_drop: got %b want 0", name, in_ready);
    end
    n = 0;
    while (!out_valid && n < 30) begin tick(); n++; end
    n_cmp++;
    if (n !== 10) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want 10", name, n);
    end
    n_cmp++;
    if (bin_out !== exp_bin) begin
      n_bad++;
      $display("FAIL %s bin_out: got %h want %h", name, bin_out, exp_bin);
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_bad++;
      $display("FAIL %s err: got %b want %b", name, err, exp_err);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s handshake: got ov=%b ir=%b want ov=0 ir=1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, err, bin_out} !== {1'b1, 1'b0, 1'b0, 10'd0}) begin
      n_bad++;
      $display("FAIL reset_state: got ir=%b ov=%b err=%b bin=%h want 1 0 0 000",
               in_ready, out_valid, err, bin_out);
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    bcd_in   = 12'h123;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_vs_valid: got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    convert(12'h255, 10'h0FF, 1'b0, "basic_255");
  endtask

  task automatic test_boundaries();
    convert(12'h000, 10'd0,   1'b0, "bound_000");
    convert(12'h999, 10'h3E7, 1'b0, "bound_999");
    convert(12'h100, 10'h064, 1'b0, "bound_100");
    convert(12'h009, 10'd9,   1'b0, "bound_009");
  endtask

  task automatic test_invalid_digit();
    convert(12'h1A0, 10'd0, 1'b1, "bad_1A0");
    convert(12'hF00, 10'd0, 1'b1, "bad_F00");
    convert(12'h037, 10'd37, 1'b0, "after_bad_037");
  endtask

  task automatic test_backpressure();
    int n;
    bcd_in   = 12'h128;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin tick(); n++; end
    n_cmp++;
    if (n !== 10) begin
      n_bad++;
      $display("FAIL bp_latency: got %0d want 10", n);
    end
    bcd_in   = 12'h777;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || bin_out !== 10'h080 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got ov=%b bin=%h ir=%b want 1 080 0",
                 i, out_valid, bin_out, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release: got ov=%b want 0", out_valid);
    end
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) n++;
    end
    n_cmp++;
    if (n !== 0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_no_777: got %0d extra results ir=%b want 0 1", n, in_ready);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bcd_in   = 12'h555;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, err, bin_out} !== {1'b1, 1'b0, 1'b0, 10'd0}) begin
      n_bad++;
      $display("FAIL midrst_state: got ir=%b ov=%b err=%b bin=%h want 1 0 0 000",
               in_ready, out_valid, err, bin_out);
    end
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) n++;
    end
    n_cmp++;
    if (n !== 0) begin
      n_bad++;
      $display("FAIL midrst_no_result: got %0d results want 0", n);
    end
    convert(12'h042, 10'h02A, 1'b0, "midrst_042");
  endtask

  task automatic test_back_to_back();
    logic [11:0] vec [3];
    int          expv [3];
    int          cyc;
    int          k;
    int          got;
    int          last;
    logic        was_rdy;
    vec[0] = 12'h001; vec[1] = 12'h064; vec[2] = 12'h500;
    expv[0] = 1;      expv[1] = 64;     expv[2] = 500;
    cyc = 0; k = 0; got = 0; last = 0;
    bcd_in    = vec[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (got < 3 && cyc < 100) begin
      was_rdy = in_ready;
      tick();
      cyc++;
      if (was_rdy && in_valid) begin
        k++;
        if (k < 3) bcd_in = vec[k];
        else       in_valid = 1'b0;
      end
      if (out_valid) begin
        n_cmp++;
        if (bin_out !== 10'(expv[got]) || err !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_res%0d: got %0d err=%b want %0d err=0",
                   got, bin_out, err, expv[got]);
        end
        if (got > 0) begin
          n_cmp++;
          if (cyc - last !== 12) begin
            n_bad++;
            $display("FAIL b2b_period%0d: got %0d want 12", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (got !== 3) begin
      n_bad++;
      $display("FAIL b2b_timeout: got %0d results want 3", got);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bcd_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_boundaries();
    test_invalid_digit();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
